// File: rtl/pid_compute_if.sv
// PID compute bus: sample request, temperatures, gains in; status and duty out.
interface pid_compute_if;
   logic       sample_tick;
   logic [9:0] set_temp;
   logic [9:0] meas_temp;
   logic [9:0] p_pa;
   logic [9:0] i_pa;
   logic [9:0] d_pa;
   logic       busy;
   logic [9:0] duty;
   logic       duty_valid;
   logic       overrun;

   modport master (
      output sample_tick, set_temp, meas_temp, p_pa, i_pa, d_pa,
      input  busy, duty, duty_valid, overrun
   );

   modport slave (
      input  sample_tick, set_temp, meas_temp, p_pa, i_pa, d_pa,
      output busy, duty, duty_valid, overrun
   );
endinterface

// File: rtl/pid_compute.sv
// Multi-cycle PID heater controller: one computation per sample_tick,
// duty in permille (0..1000). Optional anti-windup via PID_ANTI_WINDUP_EN.
module pid_compute (
   input  logic         clk,
   input  logic         rst_n,
   pid_compute_if.slave bus
);

   typedef enum logic [2:0] {IDLE, ERR, PTERM, ITERM, DTERM, SUM, OUT} state_t;

   state_t state, state_nx;

   logic [9:0]         kp, ki, kd;
   logic signed [10:0] err, prev_err, err_in;
   logic signed [13:0] integ, integ_nx;
   logic signed [14:0] integ_sum;
   logic               hold_integ;
   logic signed [25:0] p_term, i_term, d_term;
   logic signed [25:0] kp_ext, ki_ext, kd_ext;
   logic signed [25:0] err_ext, integ_ext, diff_ext, total, u;
   logic [9:0]         duty_level, duty_nx;
   logic               valid_pulse, overrun_pulse;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   // Next state: wait for a tick in IDLE, otherwise step unconditionally
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (bus.sample_tick) state_nx = ERR;
         ERR:     state_nx = PTERM;
         PTERM:   state_nx = ITERM;
         ITERM:   state_nx = DTERM;
         DTERM:   state_nx = SUM;
         SUM:     state_nx = OUT;
         OUT:     state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Arithmetic helpers: sign-extended operands, saturating integrator, clamp
   always_comb begin
      err_in    = $signed({1'b0, bus.set_temp}) - $signed({1'b0, bus.meas_temp});
      kp_ext    = $signed({16'd0, kp});
      ki_ext    = $signed({16'd0, ki});
      kd_ext    = $signed({16'd0, kd});
      err_ext   = $signed({{15{err[10]}}, err});
      diff_ext  = err_ext - $signed({{15{prev_err[10]}}, prev_err});

      integ_sum = $signed({integ[13], integ}) + $signed({{4{err[10]}}, err});
`ifdef PID_ANTI_WINDUP_EN
      hold_integ = ((duty_level == 10'd1000) && !err[10] && (err != 11'sd0)) ||
                   ((duty_level == 10'd0) && err[10]);
`else
      hold_integ = 1'b0;
`endif
      if (hold_integ)                     integ_nx = integ;
      else if (integ_sum > 15'sd4095)     integ_nx = 14'sd4095;
      else if (integ_sum < -15'sd4095)    integ_nx = -14'sd4095;
      else                                integ_nx = integ_sum[13:0];
      integ_ext = $signed({{12{integ_nx[13]}}, integ_nx});

      total = p_term + i_term + d_term;
      u     = total >>> 6;
      if (u < 26'sd0)         duty_nx = 10'd0;
      else if (u > 26'sd1000) duty_nx = 10'd1000;
      else                    duty_nx = u[9:0];
   end

   // Datapath: one term per state. The clamped duty is registered on the
   // SUM->OUT edge so that duty and duty_valid are both visible during OUT.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         kp            <= '0;
         ki            <= '0;
         kd            <= '0;
         err           <= '0;
         prev_err      <= '0;
         integ         <= '0;
         p_term        <= '0;
         i_term        <= '0;
         d_term        <= '0;
         duty_level    <= '0;
         valid_pulse   <= 1'b0;
         overrun_pulse <= 1'b0;
      end else begin
         valid_pulse   <= (state == SUM);
         overrun_pulse <= bus.sample_tick && (state != IDLE);
         case (state)
            ERR: begin
               kp  <= bus.p_pa;
               ki  <= bus.i_pa;
               kd  <= bus.d_pa;
               err <= err_in;
            end
            PTERM: p_term <= kp_ext * err_ext;
            ITERM: begin
               integ  <= integ_nx;
               i_term <= ki_ext * integ_ext;
            end
            DTERM: begin
               d_term   <= kd_ext * diff_ext;
               prev_err <= err;
            end
            SUM:     duty_level <= duty_nx;
            default: ;
         endcase
      end
   end

   assign bus.busy       = (state != IDLE);
   assign bus.duty       = duty_level;
   assign bus.duty_valid = valid_pulse;
   assign bus.overrun    = overrun_pulse;

endmodule

// File: tb/tb_pid_compute.sv
// Directed self-checking bench for pid_compute.
module tb_pid_compute;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad = 0;

   pid_compute_if bus ();

   pid_compute dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit rst;
      int set_t;
      int meas_t;
      int kp;
      int ki;
      int kd;
      int exp_duty;
   } vec_t;

   vec_t tbl[12];

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic apply(input int s, input int m, input int p, input int i, input int d);
      bus.set_temp  = 10'(s);
      bus.meas_temp = 10'(m);
      bus.p_pa      = 10'(p);
      bus.i_pa      = 10'(i);
      bus.d_pa      = 10'(d);
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst_n = 1'b0;
      bus.sample_tick = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   // Tick in cycle 0, observe cycles 1..14. Optional second tick and reset
   // assertion (held two cycles) at given cycles; -1 disables.
   task automatic run_seq(input int extra_tick, input int rst_cyc,
                          output int first_dv, output int n_dv,
                          output int ov_cyc, output int n_ov, output int n_busy);
      first_dv = -1; n_dv = 0; ov_cyc = -1; n_ov = 0; n_busy = 0;
      @(posedge clk); #1;
      bus.sample_tick = 1'b1;
      for (int c = 1; c <= 14; c++) begin
         @(posedge clk); #1;
         bus.sample_tick = (c == extra_tick);
         if (c == rst_cyc)     rst_n = 1'b0;
         if (c == rst_cyc + 2) rst_n = 1'b1;
         if (bus.duty_valid) begin
            n_dv++;
            if (first_dv < 0) first_dv = c;
         end
         if (bus.overrun) begin
            n_ov++;
            if (ov_cyc < 0) ov_cyc = c;
         end
         if (bus.busy) n_busy++;
      end
      bus.sample_tick = 1'b0;
      repeat (5) @(posedge clk);
      #1;
   endtask

   task automatic run_vec(input string name, input int exp_duty);
      int fdv, ndv, ovc, nov, nb;
      run_seq(-1, -1, fdv, ndv, ovc, nov, nb);
      check({name, " latency"}, fdv, 6);
      check({name, " valid_count"}, ndv, 1);
      check({name, " busy_cycles"}, nb, 6);
      check({name, " overrun_count"}, nov, 0);
      check({name, " duty"}, int'(bus.duty), exp_duty);
   endtask

   initial begin
      int fdv, ndv, ovc, nov, nb, dv_seen;
      bus.sample_tick = 1'b0;
      apply(0, 0, 0, 0, 0);

      tbl[0]  = '{1'b1,  500,  400,  70,  0,  0,  109};
      tbl[1]  = '{1'b1,  500,  400,   0, 10,  0,   15};
      tbl[2]  = '{1'b0,  500,  400,   0, 10,  0,   31};
      tbl[3]  = '{1'b1,  500,  400,   0,  0,  4,    6};
      tbl[4]  = '{1'b0,  500,  400,   0,  0,  4,    0};
      tbl[5]  = '{1'b1, 1000,    0,  99,  0,  0, 1000};
      tbl[6]  = '{1'b1,    0, 1000,  99,  0,  0,    0};
      tbl[7]  = '{1'b1,  300,  100, 200,  0,  0,  625};
      tbl[8]  = '{1'b1,  600,  550,  60,  5, 30,   74};
      tbl[9]  = '{1'b0,  600,  580,  60,  5, 30,   10};
      tbl[10] = '{1'b1,  600,  500, 640,  0,  0, 1000};
      tbl[11] = '{1'b1,  600,  500, 639,  0,  0,  998};

      // Reset state and idle with no tick
      #2;
      check("rst busy", int'(bus.busy), 0);
      check("rst duty", int'(bus.duty), 0);
      check("rst duty_valid", int'(bus.duty_valid), 0);
      check("rst overrun", int'(bus.overrun), 0);
      do_reset();
      dv_seen = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (bus.duty_valid || bus.busy) dv_seen++;
      end
      check("idle no activity", dv_seen, 0);
      check("idle duty", int'(bus.duty), 0);

      // Table-driven vectors
      for (int k = 0; k < 12; k++) begin
         if (tbl[k].rst) do_reset();
         apply(tbl[k].set_t, tbl[k].meas_t, tbl[k].kp, tbl[k].ki, tbl[k].kd);
         run_vec($sformatf("vec%0d", k), tbl[k].exp_duty);
      end

      // Second tick in cycle 3: overrun in cycle 4, result unaffected
      do_reset();
      apply(500, 400, 70, 0, 0);
      run_seq(3, -1, fdv, ndv, ovc, nov, nb);
      check("ovr overrun_cycle", ovc, 4);
      check("ovr overrun_count", nov, 1);
      check("ovr valid_cycle", fdv, 6);
      check("ovr valid_count", ndv, 1);
      check("ovr duty", int'(bus.duty), 109);

      // Tick during OUT: overrun, no second computation
      do_reset();
      apply(500, 400, 70, 0, 0);
      run_seq(6, -1, fdv, ndv, ovc, nov, nb);
      check("out_tick overrun_cycle", ovc, 7);
      check("out_tick valid_count", ndv, 1);
      check("out_tick busy_cycles", nb, 6);

      // Reset mid-computation clears integrator and suppresses the update
      do_reset();
      apply(500, 400, 0, 10, 0);
      run_vec("mid_rst pre", 15);
      run_seq(-1, 3, fdv, ndv, ovc, nov, nb);
      check("mid_rst valid_count", ndv, 0);
      check("mid_rst duty", int'(bus.duty), 0);
      check("mid_rst busy", int'(bus.busy), 0);
      check("mid_rst integ", int'(dut.integ), 0);
      run_vec("mid_rst post", 15);

      // Integrator windup
      do_reset();
      apply(1000, 0, 99, 10, 0);
      for (int k = 0; k < 10; k++) run_vec($sformatf("wind%0d", k), 1000);
`ifdef PID_ANTI_WINDUP_EN
      check("wind integ", int'(dut.integ), 1000);
      apply(100, 200, 99, 10, 0);
      run_vec("wind reverse", 0);
`else
      check("wind integ", int'(dut.integ), 4095);
      apply(100, 200, 99, 10, 0);
      run_vec("wind reverse", 469);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pid_compute.md
PID_COMPUTE -- requirements
Module: pid_compute

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk  in  1  system clock, rising edge; rst_n  in  1  asynchronous reset, active low.
REQ-002 sample_tick  in  1  one-cycle pulse that starts one control computation.
REQ-003 set_temp  in  10  setpoint temperature, unsigned.
REQ-004 meas_temp  in  10  measured temperature, unsigned.
REQ-005 p_pa, i_pa, d_pa  in  10 each  proportional, integral and derivative gains, unsigned, nominal 0..99, produced by the gain-entry stage.
REQ-006 busy  out  1  high while a computation is in progress.
REQ-007 duty  out  10  heater duty in permille, 0..1000, held between updates.
REQ-008 duty_valid  out  1  one-cycle pulse when duty takes a new value.
REQ-009 overrun  out  1  one-cycle pulse when sample_tick arrives while busy is high.

Function
REQ-010 The FSM SHALL have states IDLE, ERR, PTERM, ITERM, DTERM, SUM and OUT, and SHALL advance unconditionally one state per clock from ERR to OUT and from OUT to IDLE.
REQ-011 IDLE SHALL go to ERR on sample_tick; busy SHALL be high in every state except IDLE.
REQ-012 ERR SHALL latch set_temp, meas_temp and the three gains, and compute e = set_temp - meas_temp as signed 11-bit; input changes after this point SHALL NOT affect the current result.
REQ-013 PTERM SHALL compute P = Kp*e (signed).
REQ-014 ITERM SHALL update integ = integ + e, saturating at +4095/-4095 (signed 14-bit), then compute I = Ki*integ.
REQ-015 DTERM SHALL compute D = Kd*(e - prev_err) and then set prev_err = e.
REQ-016 SUM SHALL form u = (P + I + D) >>> 6 (arithmetic shift) in a signed accumulator of at least 24 bits, with no intermediate overflow.
REQ-017 OUT SHALL set duty = 0 if u < 0, 1000 if u > 1000, u otherwise, and SHALL pulse duty_valid.
REQ-018 Latency: with sample_tick high in cycle 0, duty_valid SHALL be high in cycle 6 and duty SHALL hold the new value from cycle 6.
REQ-019 A sample_tick while busy is high SHALL be dropped and SHALL pulse overrun in the following cycle; the current computation SHALL continue unaffected.
REQ-020 A sample_tick during OUT SHALL count as an overrun; a new computation SHALL start only from IDLE.
REQ-021 Gains above 99 SHALL be used as given, without clamping.

Reset
REQ-022 While rst_n is low, the block SHALL set state = IDLE, integ = 0, prev_err = 0, duty = 0, busy = 0, duty_valid = 0 and overrun = 0.
REQ-023 Reset asserted mid-computation SHALL abort the computation with no duty_valid pulse.
REQ-024 The first sample_tick after reset SHALL use prev_err = 0.

Configuration
REQ-025 With macro PID_ANTI_WINDUP_EN defined, ITERM SHALL skip the integ update when the previous duty was 1000 and e > 0, or when the previous duty was 0 and e < 0.
REQ-026 Without PID_ANTI_WINDUP_EN, integ SHALL always update per REQ-014.

Verification
REQ-027 Reset, then no tick -> duty = 0, duty_valid never high, busy = 0.
REQ-028 Kp = 70, Ki = 0, Kd = 0, set = 500, meas = 400, one tick -> duty_valid in cycle 6, duty = 109 (7000 >>> 6).
REQ-029 Kp = 0, Ki = 10, Kd = 0, e = 100, two ticks 20 cycles apart -> duty = 15, then 31; Kd = 4 only, first tick e = 100 -> duty = 6.
REQ-030 Kp = 99, set = 1000, meas = 0 -> duty = 1000; set = 0, meas = 1000 -> duty = 0.
REQ-031 Tick repeated in cycle 3 -> overrun pulse in cycle 4, a single duty_valid in cycle 6, result unchanged; rst_n low in cycle 3 -> no duty_valid, duty = 0, integ cleared.
REQ-032 Ki = 10, Kp = 99, e = 1000, 10 ticks, then e = -100 -> with PID_ANTI_WINDUP_EN, integ = 1000 before the sign change; without it, integ = 4095 (saturated).
